// File: rtl/bist_controller_param.sv
// -----------------------------------------------------------------------------
// bist_controller_param
//
// Built-in self-test controller for a combinational CUT. The block owns the
// pattern LFSR, the response MISR and the functional/test input mux. A small
// four-state FSM runs one test of NUM_PATTERNS patterns per accepted start.
// At the end it compares the compacted signature against GOLDEN_SIG.
//
// State table
//   state     | meaning
//   S_IDLE    | waiting for start with testmode high; signature and result hold
//   S_RUN     | one pattern per cycle: MISR absorbs cut_resp, LFSR advances
//   S_COMPARE | signature is final; result registers load at this edge
//   S_DONE    | test_done pulse for one cycle, then back to idle
//
// Ports
//   clock          : single rising-edge clock
//   reset          : asynchronous, active-high
//   testmode       : 1 = BIST drives the CUT inputs
//   start          : test request, sampled in S_IDLE only
//   func_in        : functional CUT inputs
//   cut_in         : CUT inputs, testmode ? LFSR state : func_in
//   cut_resp       : CUT response
//   signature      : current MISR state
//   busy           : high in S_RUN and S_COMPARE
//   test_done      : one-cycle pulse when the result is valid
//   fault_detected : signature mismatch on the last completed test
//   pass           : signature match on the last completed test
// -----------------------------------------------------------------------------
module bist_controller_param #(
  parameter int                   PAT_W        = 3,
  parameter int                   RSP_W        = 2,
  parameter int                   SIG_W        = 4,
  parameter logic [PAT_W-1:0]     LFSR_TAPS    = 3'b110,
  parameter logic [PAT_W-1:0]     LFSR_SEED    = 3'b001,
  parameter logic [SIG_W-1:0]     MISR_TAPS    = 4'b1001,
  parameter int                   NUM_PATTERNS = 7,
  parameter logic [SIG_W-1:0]     GOLDEN_SIG   = 4'b0011
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             testmode,
  input  logic             start,
  input  logic [PAT_W-1:0] func_in,
  output logic [PAT_W-1:0] cut_in,
  input  logic [RSP_W-1:0] cut_resp,
  output logic [SIG_W-1:0] signature,
  output logic             busy,
  output logic             test_done,
  output logic             fault_detected,
  output logic             pass
);

  localparam int CNT_W = $clog2(NUM_PATTERNS) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_COMPARE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] lfsr_q, lfsr_d;
  logic [SIG_W-1:0] misr_q, misr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pass_q, pass_d;
  logic             fault_q, fault_d;

  logic             lfsr_fb;
  logic [PAT_W-1:0] lfsr_next;
  logic             misr_fb;
  logic [SIG_W-1:0] misr_next;
  logic [SIG_W-1:0] resp_ext;

  // Fibonacci LFSR, shifting left with the feedback bit entering at the LSB.
  assign lfsr_fb   = ^(lfsr_q & LFSR_TAPS);
  assign lfsr_next = {lfsr_q[PAT_W-2:0], lfsr_fb};

  // MISR: same shift structure, with the response folded into the low bits.
  assign resp_ext  = SIG_W'(cut_resp);
  assign misr_fb   = ^(misr_q & MISR_TAPS);
  assign misr_next = {misr_q[SIG_W-2:0], misr_fb} ^ resp_ext;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= LFSR_SEED;
      misr_q  <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    fault_d = fault_q;

    // Results are only meaningful in BIST mode; leaving it clears them.
    if (!testmode) begin
      pass_d  = 1'b0;
      fault_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start && testmode) begin
          lfsr_d  = LFSR_SEED;
          misr_d  = '0;
          cnt_d   = '0;
          pass_d  = 1'b0;
          fault_d = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Abort holds LFSR and MISR so the partial signature stays visible.
        if (!testmode) begin
          state_d = S_IDLE;
        end else begin
          misr_d = misr_next;
          lfsr_d = lfsr_next;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = S_COMPARE;
          end
        end
      end
      S_COMPARE: begin
        if (!testmode) begin
          state_d = S_IDLE;
        end else begin
          fault_d = (misr_q != GOLDEN_SIG);
          pass_d  = (misr_q == GOLDEN_SIG);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cut_in         = testmode ? lfsr_q : func_in;
  assign signature      = misr_q;
  assign busy           = (state_q == S_RUN) || (state_q == S_COMPARE);
  assign test_done      = (state_q == S_DONE);
  assign pass           = pass_q;
  assign fault_detected = fault_q;

endmodule

// File: tb/tb_bist_controller_param.sv
module tb_bist_controller_param;

  localparam int          PAT_W        = 3;
  localparam int          RSP_W        = 2;
  localparam int          SIG_W        = 4;
  localparam logic [2:0]  LFSR_TAPS    = 3'b110;
  localparam logic [2:0]  LFSR_SEED    = 3'b001;
  localparam logic [3:0]  MISR_TAPS    = 4'b1001;
  localparam int          NUM_PATTERNS = 7;
  localparam logic [3:0]  GOLDEN_SIG   = 4'b0011;

  logic             clock;
  logic             reset;
  logic             testmode;
  logic             start;
  logic [PAT_W-1:0] func_in;
  logic [PAT_W-1:0] cut_in;
  logic [RSP_W-1:0] cut_resp;
  logic [SIG_W-1:0] signature;
  logic             busy;
  logic             test_done;
  logic             fault_detected;
  logic             pass;

  logic             use_fa;
  logic [RSP_W-1:0] resp_drv;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_runs   = 0;

  typedef struct {
    logic [SIG_W-1:0] sig;
    logic             pass;
  } exp_t;

  exp_t sb_q[$];
  int   resp_arr[NUM_PATTERNS];

  bist_controller_param #(
    .PAT_W(PAT_W), .RSP_W(RSP_W), .SIG_W(SIG_W),
    .LFSR_TAPS(LFSR_TAPS), .LFSR_SEED(LFSR_SEED), .MISR_TAPS(MISR_TAPS),
    .NUM_PATTERNS(NUM_PATTERNS), .GOLDEN_SIG(GOLDEN_SIG)
  ) dut (
    .clock(clock), .reset(reset), .testmode(testmode), .start(start),
    .func_in(func_in), .cut_in(cut_in), .cut_resp(cut_resp),
    .signature(signature), .busy(busy), .test_done(test_done),
    .fault_detected(fault_detected), .pass(pass)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Full adder CUT: the response is {sum, carry} of the number of ones.
  function automatic int fa(input int p);
    int ones;
    ones = ((p >> 2) & 1) + ((p >> 1) & 1) + (p & 1);
    return ((ones % 2) << 1) | (ones / 2);
  endfunction

  assign cut_resp = use_fa ? 2'(fa(int'(cut_in))) : resp_drv;

  // Pattern applied in RUN cycle k (k counted from 0).
  function automatic int model_pattern(input int k);
    int s;
    int fb;
    s = int'(LFSR_SEED);
    for (int i = 0; i < k; i++) begin
      fb = $countones(s & int'(LFSR_TAPS)) % 2;
      s  = ((s * 2) + fb) % (1 << PAT_W);
    end
    return s;
  endfunction

  // Signature after compacting the first n entries of resp_arr from zero.
  function automatic int model_sig(input int n);
    int s;
    int fb;
    s = 0;
    for (int i = 0; i < n; i++) begin
      fb = $countones(s & int'(MISR_TAPS)) % 2;
      s  = (((s * 2) + fb) % (1 << SIG_W)) ^ resp_arr[i];
    end
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // mode: 0 resp=01, 1 resp=00, 2 random per cycle, 3 full adder CUT.
  // abort_at >= 0 drops testmode in that RUN cycle.
  task automatic do_run(input int mode, input bit hold_start, input int abort_at);
    exp_t e;
    for (int k = 0; k < NUM_PATTERNS; k++) begin
      case (mode)
        0:       resp_arr[k] = 1;
        1:       resp_arr[k] = 0;
        2:       resp_arr[k] = int'($urandom_range(0, 3));
        default: resp_arr[k] = fa(model_pattern(k));
      endcase
    end
    use_fa = (mode == 3);
    if (abort_at < 0) begin
      e.sig  = 4'(model_sig(NUM_PATTERNS));
      e.pass = (e.sig == GOLDEN_SIG);
      sb_q.push_back(e);
      n_runs++;
    end
    testmode = 1'b1;
    start    = 1'b1;
    step();
    if (!hold_start) start = 1'b0;
    for (int k = 0; k < NUM_PATTERNS; k++) begin
      if (!use_fa) resp_drv = 2'(resp_arr[k]);
      func_in = 3'($urandom);
      #1;
      check("run_cut_in", 32'(cut_in), 32'(model_pattern(k)));
      check("run_busy", 32'(busy), 32'd1);
      check("run_no_done", 32'(test_done), 32'd0);
      if (k == abort_at) begin
        testmode = 1'b0;
        step();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_no_done", 32'(test_done), 32'd0);
        check("abort_pass", 32'(pass), 32'd0);
        check("abort_fault", 32'(fault_detected), 32'd0);
        check("abort_sig_hold", 32'(signature), 32'(model_sig(k)));
        testmode = 1'b1;
        start    = 1'b0;
        return;
      end
      step();
    end
    check("compare_busy", 32'(busy), 32'd1);
    check("compare_no_done", 32'(test_done), 32'd0);
    step();
    check("done_busy", 32'(busy), 32'd0);
    check("done_pulse", 32'(test_done), 32'd1);
    step();
    check("idle_no_done", 32'(test_done), 32'd0);
  endtask

  // Scoreboard monitor: pops one expectation per test_done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (test_done === 1'b1) begin
        n_done++;
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done actual=1 required=0 at t=%0t", $time);
        end else begin
          e = sb_q.pop_front();
          check("sb_signature", 32'(signature), 32'(e.sig));
          check("sb_pass", 32'(pass), 32'(e.pass));
          check("sb_fault", 32'(fault_detected), 32'(!e.pass));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    testmode = 1'b1;
    start    = 1'b0;
    func_in  = '0;
    resp_drv = '0;
    use_fa   = 1'b0;
    #3;
    check("rst_signature", 32'(signature), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(test_done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_fault", 32'(fault_detected), 32'd0);
    check("rst_cut_in_seed", 32'(cut_in), 32'(LFSR_SEED));
    #9;
    reset = 1'b0;
    step();

    // Golden pass, fault, then pass again clearing the fault.
    do_run(0, 1'b0, -1);
    do_run(1, 1'b0, -1);
    do_run(0, 1'b0, -1);

    // Functional mode: mux follows func_in, start ignored, results cleared.
    testmode = 1'b0;
    func_in  = 3'b101;
    start    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("func_cut_in", 32'(cut_in), 32'(func_in));
      check("func_busy", 32'(busy), 32'd0);
      check("func_fault", 32'(fault_detected), 32'd0);
      check("func_pass", 32'(pass), 32'd0);
      func_in = 3'($urandom);
      #1;
      check("func_cut_in_live", 32'(cut_in), 32'(func_in));
    end
    start = 1'b0;

    // Abort in the third RUN cycle, then a clean restart.
    do_run(0, 1'b0, 2);
    step();
    do_run(0, 1'b0, -1);

    // Asynchronous reset in the fourth RUN cycle.
    testmode = 1'b1;
    use_fa   = 1'b0;
    resp_drv = 2'b01;
    start    = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    #1;
    check("mid_rst_signature", 32'(signature), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(test_done), 32'd0);
    check("mid_rst_pass", 32'(pass), 32'd0);
    check("mid_rst_fault", 32'(fault_detected), 32'd0);
    check("mid_rst_cut_in", 32'(cut_in), 32'(LFSR_SEED));
    #4;
    reset = 1'b0;
    step();
    check("post_rst_busy", 32'(busy), 32'd0);

    // start held across a whole run and DONE: exactly one follow-on run.
    do_run(0, 1'b1, -1);
    do_run(3, 1'b0, -1);
    repeat (3) begin
      step();
      check("no_extra_run", 32'(busy), 32'd0);
    end

    // Randomised runs.
    for (int r = 0; r < 24; r++) begin
      int  mode;
      bit  hold;
      int  abort_at;
      mode     = int'($urandom_range(0, 3));
      hold     = (r < 23) && ($urandom_range(0, 2) == 0);
      abort_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NUM_PATTERNS - 1)) : -1;
      do_run(mode, hold, abort_at);
      if (abort_at >= 0) step();
    end

    repeat (4) step();
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("done_count", 32'(n_done), 32'(n_runs));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
